// File: rtl/i3c_pkg.sv
// Shared I3C types: transfer classification, broadcast address and the
// target frame decoder state encoding.
package i3c_pkg;

  localparam logic [6:0] I3C_BCAST_ADDR = 7'h7E;

  typedef enum logic [1:0] {
    XFER_WRITE = 2'b00,
    XFER_READ  = 2'b01,
    XFER_CCC   = 2'b10
  } transfer_type_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_CCC_CODE,
    ST_DATA,
    ST_TBIT,
    ST_READ,
    ST_IGNORE
  } fd_state_e;

  typedef enum logic [1:0] {
    HDR_NONE,
    HDR_BCAST_W,
    HDR_OWN_W,
    HDR_OWN_R
  } hdr_kind_e;

endpackage

// File: rtl/i3c_bit_shifter.sv
// MSB-first shifter for 9-bit SDR words; word_o/odd_o include the bit being
// presented this cycle so the caller can act on the last bit without delay.
module i3c_bit_shifter (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       clr_i,
  input  logic       bit_valid_i,
  input  logic       bit_i,
  output logic [3:0] cnt_o,
  output logic [8:0] word_o,
  output logic       odd_o
);

  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sh_q, sh_d;

  assign word_o = {sh_q, bit_i};
  assign odd_o  = ^word_o;
  assign cnt_o  = cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    sh_d  = sh_q;
    if (clr_i) begin
      cnt_d = 4'd0;
      sh_d  = 8'd0;
    end else if (bit_valid_i) begin
      sh_d  = word_o[7:0];
      cnt_d = (cnt_q == 4'd8) ? 4'd0 : cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= 4'd0;
      sh_q  <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
    end
  end

endmodule

// File: rtl/i3c_target_frame_decoder.sv
// I3C SDR target frame decoder: header match, ACK request, T-bit check and a
// one-deep holding register feeding the standby flow block.
module i3c_target_frame_decoder
  import i3c_pkg::*;
#(
  parameter int                   AddrWidth     = 7,
  parameter logic [AddrWidth-1:0] BroadcastAddr = I3C_BCAST_ADDR
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic [AddrWidth-1:0] target_addr_i,
  input  logic                 target_addr_valid_i,
  input  logic                 bus_start_det_i,
  input  logic                 bus_stop_det_i,
  input  logic                 bit_valid_i,
  input  logic                 bit_i,
  output logic                 ack_o,
  output logic                 transfer_start_o,
  output logic                 transfer_stop_o,
  output logic [1:0]           transfer_type_o,
  output logic                 rx_byte_valid_o,
  output logic [7:0]           rx_byte_o,
  input  logic                 rx_byte_ready_i,
  output logic                 parity_err_o,
  output logic                 overflow_err_o
);

  fd_state_e      state_q, state_d;
  hdr_kind_e      kind_q, kind_d;
  transfer_type_e type_q, type_d;
  logic           active_q, active_d;
  logic           start_q, start_d, stop_q, stop_d;
  logic           perr_q, perr_d, ovf_q, ovf_d;
  logic           hold_vld_q, hold_vld_d;
  logic [7:0]     hold_q, hold_d;
  logic           load;
  logic           sh_clr, sh_odd;
  logic [3:0]     sh_cnt;
  logic [8:0]     sh_word;
  logic [AddrWidth:0] hdr;

  assign sh_clr = !enable_i || bus_stop_det_i || bus_start_det_i || (state_q == ST_IDLE);
  assign hdr    = sh_word[AddrWidth:0];

  i3c_bit_shifter u_shifter (
    .clk_i       (clk_i),
    .rst_ni      (rst_ni),
    .clr_i       (sh_clr),
    .bit_valid_i (bit_valid_i),
    .bit_i       (bit_i),
    .cnt_o       (sh_cnt),
    .word_o      (sh_word),
    .odd_o       (sh_odd)
  );

  always_comb begin
    state_d  = state_q;
    kind_d   = kind_q;
    type_d   = type_q;
    active_d = active_q;
    start_d  = 1'b0;
    stop_d   = 1'b0;
    perr_d   = 1'b0;
    load     = 1'b0;
    // STOP and disable share one exit; Sr restarts header decoding.
    if (!enable_i || bus_stop_det_i) begin
      state_d  = ST_IDLE;
      stop_d   = active_q;
      active_d = 1'b0;
    end else if (bus_start_det_i) begin
      state_d  = ST_ADDR;
      stop_d   = active_q;
      active_d = 1'b0;
    end else if (bit_valid_i) begin
      unique case (state_q)
        ST_ADDR: if (sh_cnt == 4'd7) begin
          if (hdr == {BroadcastAddr, 1'b0})
            kind_d = HDR_BCAST_W;
          else if (target_addr_valid_i && hdr[AddrWidth:1] == target_addr_i)
            kind_d = hdr[0] ? HDR_OWN_R : HDR_OWN_W;
          else
            kind_d = HDR_NONE;
          state_d = (kind_d == HDR_NONE) ? ST_IGNORE : ST_ADDR_ACK;
        end
        ST_ADDR_ACK: begin
          if (kind_q == HDR_BCAST_W) begin
            state_d = ST_CCC_CODE;
          end else begin
            state_d  = (kind_q == HDR_OWN_R) ? ST_READ : ST_DATA;
            type_d   = (kind_q == HDR_OWN_R) ? XFER_READ : XFER_WRITE;
            start_d  = 1'b1;
            active_d = 1'b1;
          end
        end
        ST_CCC_CODE: if (sh_cnt == 4'd8) begin
          if (sh_odd) begin
            state_d  = ST_DATA;
            type_d   = XFER_CCC;
            start_d  = 1'b1;
            active_d = 1'b1;
            load     = 1'b1;
          end else begin
            state_d = ST_IGNORE;
            perr_d  = 1'b1;
          end
        end
        ST_DATA: if (sh_cnt == 4'd7) state_d = ST_TBIT;
        ST_TBIT: begin
          state_d = sh_odd ? ST_DATA : ST_IGNORE;
          load    = sh_odd;
          perr_d  = !sh_odd;
        end
        default: ;
      endcase
    end
  end

  // A load beats a same-cycle handshake; a load into a still-full register drops.
  always_comb begin
    hold_vld_d = hold_vld_q;
    hold_d     = hold_q;
    ovf_d      = 1'b0;
    if (load) begin
      if (hold_vld_q && !rx_byte_ready_i) begin
        ovf_d = 1'b1;
      end else begin
        hold_vld_d = 1'b1;
        hold_d     = sh_word[8:1];
      end
    end else if (hold_vld_q && rx_byte_ready_i) begin
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      kind_q     <= HDR_NONE;
      type_q     <= XFER_WRITE;
      active_q   <= 1'b0;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      perr_q     <= 1'b0;
      ovf_q      <= 1'b0;
      hold_vld_q <= 1'b0;
      hold_q     <= 8'd0;
    end else begin
      state_q    <= state_d;
      kind_q     <= kind_d;
      type_q     <= type_d;
      active_q   <= active_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      perr_q     <= perr_d;
      ovf_q      <= ovf_d;
      hold_vld_q <= hold_vld_d;
      hold_q     <= hold_d;
    end
  end

  assign ack_o            = (state_q == ST_ADDR_ACK);
  assign transfer_start_o = start_q;
  assign transfer_stop_o  = stop_q;
  assign transfer_type_o  = type_q;
  assign rx_byte_valid_o  = hold_vld_q;
  assign rx_byte_o        = hold_q;
  assign parity_err_o     = perr_q;
  assign overflow_err_o   = ovf_q;

endmodule

// File: tb/tb_i3c_target_frame_decoder.sv
// Bench for the target frame decoder: vector table, hand-built bus corner
// sequences and randomized transfers against a transfer-level model.
`timescale 1ns/1ps
module tb_i3c_target_frame_decoder;

  logic       clk = 1'b0;
  logic       rst_n, enable, tgt_vld, start, stop, bv, b, ready;
  logic [6:0] tgt;
  logic       ack, xs, xp, rxv, perr, ovf;
  logic [1:0] xtype;
  logic [7:0] rxb;

  int checks = 0;
  int errors = 0;

  int         st_q[$];
  logic [7:0] rx_q[$];
  int         n_stop, n_perr, n_ovf;

  always #5 clk = ~clk;

  i3c_target_frame_decoder dut (
    .clk_i(clk), .rst_ni(rst_n), .enable_i(enable),
    .target_addr_i(tgt), .target_addr_valid_i(tgt_vld),
    .bus_start_det_i(start), .bus_stop_det_i(stop),
    .bit_valid_i(bv), .bit_i(b),
    .ack_o(ack), .transfer_start_o(xs), .transfer_stop_o(xp),
    .transfer_type_o(xtype), .rx_byte_valid_o(rxv), .rx_byte_o(rxb),
    .rx_byte_ready_i(ready), .parity_err_o(perr), .overflow_err_o(ovf)
  );

  always @(negedge clk) begin
    if (xs) st_q.push_back(int'(xtype));
    if (xp) n_stop++;
    if (perr) n_perr++;
    if (ovf) n_ovf++;
    if (rxv && ready) rx_q.push_back(rxb);
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic clr_mon();
    st_q.delete(); rx_q.delete();
    n_stop = 0; n_perr = 0; n_ovf = 0;
  endtask

  task automatic pulse_start();
    start = 1'b1; tick(); start = 1'b0; tick();
  endtask

  task automatic pulse_stop();
    stop = 1'b1; tick(); stop = 1'b0; tick();
  endtask

  task automatic send_bit(input logic v, input int gap);
    b = v; bv = 1'b1; tick(); bv = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [7:0] d, input logic t, input int gap);
    for (int i = 7; i >= 0; i--) send_bit(d[i], gap);
    send_bit(t, gap);
  endtask

  // Header bits, then ACK observed before the 9th slot is clocked.
  task automatic send_hdr(input logic [7:0] h, input int gap, output logic ack_seen);
    for (int i = 7; i >= 0; i--) send_bit(h[i], gap);
    ack_seen = ack;
    send_bit(1'b0, gap);
  endtask

  typedef struct {
    logic [7:0] hdr;
    logic       tv;
    logic [7:0] data;
    logic       t;
    int         nsend;
    int         e_ack, e_starts, e_type, e_bytes, e_perr, e_stops;
  } vec_t;

  vec_t vecs[9];
  logic ack_seen;

  int         e_types[$];
  logic [7:0] e_bytes[$];
  int         e_perr, e_stops;

  initial begin
    rst_n = 1'b0; enable = 1'b1; tgt = 7'h5A; tgt_vld = 1'b1;
    start = 1'b0; stop = 1'b0; bv = 1'b0; b = 1'b0; ready = 1'b1;
    repeat (3) tick();
    chk("reset_outputs", int'({ack, xs, xp, xtype, rxv, rxb, perr, ovf}), 0);
    rst_n = 1'b1;
    tick();

    vecs[0] = '{8'hB4, 1'b1, 8'h3C, 1'b1, 1, 1, 1, 0, 1, 0, 1};
    vecs[1] = '{8'hB5, 1'b1, 8'h3C, 1'b1, 1, 1, 1, 1, 0, 0, 1};
    vecs[2] = '{8'hFC, 1'b1, 8'h06, 1'b1, 1, 1, 1, 2, 1, 0, 1};
    vecs[3] = '{8'hB4, 1'b1, 8'h3C, 1'b0, 2, 1, 1, 0, 0, 1, 1};
    vecs[4] = '{8'h22, 1'b1, 8'h3C, 1'b1, 1, 0, 0, 0, 0, 0, 0};
    vecs[5] = '{8'hFD, 1'b1, 8'h3C, 1'b1, 1, 0, 0, 0, 0, 0, 0};
    vecs[6] = '{8'hB4, 1'b0, 8'h3C, 1'b1, 1, 0, 0, 0, 0, 0, 0};
    vecs[7] = '{8'hFC, 1'b1, 8'h06, 1'b0, 1, 1, 0, 0, 0, 1, 0};
    vecs[8] = '{8'hB4, 1'b1, 8'h3C, 1'b1, 2, 1, 1, 0, 2, 0, 1};

    for (int v = 0; v < 9; v++) begin
      tgt_vld = vecs[v].tv;
      clr_mon();
      pulse_start();
      send_hdr(vecs[v].hdr, 1, ack_seen);
      repeat (vecs[v].nsend) send_word(vecs[v].data, vecs[v].t, 1);
      pulse_stop();
      repeat (3) tick();
      chk($sformatf("v%0d_ack", v), int'(ack_seen), vecs[v].e_ack);
      chk($sformatf("v%0d_starts", v), st_q.size(), vecs[v].e_starts);
      if (vecs[v].e_starts > 0 && st_q.size() > 0)
        chk($sformatf("v%0d_type", v), st_q[0], vecs[v].e_type);
      chk($sformatf("v%0d_bytes", v), rx_q.size(), vecs[v].e_bytes);
      foreach (rx_q[i]) chk($sformatf("v%0d_byte%0d", v, i), int'(rx_q[i]), int'(vecs[v].data));
      chk($sformatf("v%0d_perr", v), n_perr, vecs[v].e_perr);
      chk($sformatf("v%0d_stops", v), n_stop, vecs[v].e_stops);
    end
    tgt_vld = 1'b1;

    // Overflow with a stalled consumer, then release.
    clr_mon(); ready = 1'b0;
    pulse_start();
    send_hdr(8'hB4, 1, ack_seen);
    for (int i = 7; i >= 0; i--) send_bit(logic'(8'h01 >> i), 1);
    b = 1'b0; bv = 1'b1;
    chk("ovf_valid_before", int'(rxv), 0);
    tick(); bv = 1'b0;
    chk("ovf_latency_valid", int'(rxv), 1);
    chk("ovf_first_byte", int'(rxb), 8'h01);
    tick();
    send_word(8'h02, 1'b0, 1);
    tick();
    chk("ovf_pulses", n_ovf, 1);
    chk("ovf_byte_kept", int'(rxb), 8'h01);
    chk("ovf_still_valid", int'(rxv), 1);
    ready = 1'b1;
    tick();
    chk("ovf_valid_drop", int'(rxv), 0);
    chk("ovf_delivered", rx_q.size(), 1);
    if (rx_q.size() > 0) chk("ovf_delivered_byte", int'(rx_q[0]), 8'h01);
    pulse_stop(); tick();
    chk("ovf_stops", n_stop, 1);

    // Broadcast W, Sr, own address: private write only.
    clr_mon();
    pulse_start();
    send_hdr(8'hFC, 1, ack_seen);
    pulse_start();
    chk("sr_no_stop", n_stop, 0);
    send_hdr(8'hB4, 1, ack_seen);
    chk("sr_ack", int'(ack_seen), 1);
    send_word(8'h3C, 1'b1, 1);
    pulse_stop(); tick();
    chk("sr_starts", st_q.size(), 1);
    if (st_q.size() > 0) chk("sr_type", st_q[0], 0);
    chk("sr_bytes", rx_q.size(), 1);
    chk("sr_stops", n_stop, 1);

    // Sr during an active write ends it; following read keeps its type after P.
    clr_mon();
    pulse_start();
    send_hdr(8'hB4, 1, ack_seen);
    send_word(8'h3C, 1'b1, 1);
    pulse_start();
    chk("sr_active_stop", n_stop, 1);
    send_hdr(8'hB5, 1, ack_seen);
    tick();
    chk("sr_read_type", int'(xtype), 1);
    send_word(8'hA5, 1'b1, 0);
    pulse_stop(); tick();
    chk("sr_read_stops", n_stop, 2);
    chk("sr_read_starts", st_q.size(), 2);
    chk("type_held_after_stop", int'(xtype), 1);
    chk("sr_read_bytes", rx_q.size(), 1);

    // Enable dropped mid-transfer.
    clr_mon();
    pulse_start();
    send_hdr(8'hB4, 1, ack_seen);
    enable = 1'b0; tick(); enable = 1'b1; tick();
    chk("en_stop", n_stop, 1);
    send_word(8'h3C, 1'b1, 1);
    pulse_stop(); tick();
    chk("en_no_bytes", rx_q.size(), 0);
    chk("en_stop_once", n_stop, 1);

    // STOP and START together: STOP wins, decoder idles.
    clr_mon();
    pulse_start();
    send_hdr(8'hB4, 1, ack_seen);
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0; tick();
    chk("ps_stop", n_stop, 1);
    send_hdr(8'hB4, 1, ack_seen);
    chk("ps_idle_ack", int'(ack_seen), 0);
    chk("ps_starts", st_q.size(), 1);

    // Reset mid-transfer: no stop pulse, outputs cleared.
    clr_mon();
    pulse_start();
    send_hdr(8'hB5, 1, ack_seen);
    rst_n = 1'b0; tick();
    chk("rst_outputs", int'({ack, xs, xp, xtype, rxv, rxb, perr, ovf}), 0);
    rst_n = 1'b1; repeat (2) tick();
    chk("rst_no_stop", n_stop, 0);

    // Randomized transfers against a transfer-level model.
    for (int n = 0; n < 40; n++) begin
      logic [7:0] h, d[4];
      logic       t[4];
      int         nb, gap;
      bit         own, bw, alive;
      case ($urandom_range(0, 4))
        0: h = {tgt, 1'b0};
        1: h = {tgt, 1'b1};
        2: h = 8'hFC;
        3: h = 8'hFD;
        default: h = 8'($urandom);
      endcase
      nb  = $urandom_range(0, 3);
      gap = $urandom_range(0, 2);
      for (int i = 0; i < 4; i++) begin
        d[i] = 8'($urandom);
        t[i] = (($countones(d[i]) % 2) == 0);
        if ($urandom_range(0, 4) == 0) t[i] = ~t[i];
      end
      own = (h[7:1] == tgt);
      bw  = (h == 8'hFC);
      e_types.delete(); e_bytes.delete(); e_perr = 0; e_stops = 0;
      if (own && h[0]) begin
        e_types.push_back(1);
      end else if (own || (bw && nb > 0)) begin
        alive = 1'b1;
        if (own) e_types.push_back(0);
        for (int i = 0; i < nb; i++) begin
          if (alive) begin
            if (($countones({d[i], t[i]}) % 2) == 1) begin
              if (bw && i == 0) e_types.push_back(2);
              e_bytes.push_back(d[i]);
            end else begin
              e_perr++;
              alive = 1'b0;
            end
          end
        end
      end
      e_stops = e_types.size();

      clr_mon();
      pulse_start();
      send_hdr(h, gap, ack_seen);
      for (int i = 0; i < nb; i++) send_word(d[i], t[i], gap);
      pulse_stop();
      repeat (3) tick();
      chk($sformatf("r%0d_ack", n), int'(ack_seen), int'(own || bw));
      chk($sformatf("r%0d_starts", n), st_q.size(), e_types.size());
      if (st_q.size() == e_types.size())
        foreach (st_q[i]) chk($sformatf("r%0d_type", n), st_q[i], e_types[i]);
      chk($sformatf("r%0d_nbytes", n), rx_q.size(), e_bytes.size());
      if (rx_q.size() == e_bytes.size())
        foreach (rx_q[i]) chk($sformatf("r%0d_byte%0d", n, i), int'(rx_q[i]), int'(e_bytes[i]));
      chk($sformatf("r%0d_perr", n), n_perr, e_perr);
      chk($sformatf("r%0d_stops", n), n_stop, e_stops);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
